// File: rtl/acc_share_sched_pkg.sv
// Shared definitions for the accumulator-sharing scheduler.
//   N_DEF / T_MAX_DEF : default datapath width and largest legal exponent
//   state_t           : scheduler FSM encoding
//   iter_limit()      : last counter value of a job, (1<<t)-1
package acc_share_sched_pkg;

  localparam int N_DEF     = 8;
  localparam int T_MAX_DEF = N_DEF - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] iter_limit(input logic [31:0] t);
    return (32'd1 << t) - 32'd1;
  endfunction

endpackage

// File: rtl/acc_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   en         : arbitration allowed (scheduler idle)
//   valid[1:0] : request valids, bit0 = requester 0
//   grant[1:0] : one-hot combinational grant
// last_grant resets to 1 so requester 0 wins the first tie.
module acc_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // A grant is always taken (grant implies valid), so it updates history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[1];
  end

endmodule

// File: rtl/acc_share_sched.sv
// Shares one external combinational accumulator datapath between two
// requesters. A granted job latches operand/t, then runs the datapath for
// 2^t cycles feeding the registered sum back, and returns the final sum
// through a valid/ready result port tagged with the requester id.
//   req_valid/req_ready[1:0], req_operand0/1, req_t0/1 : request side
//   res_valid/res_ready, res_id, res_data, res_err      : result side
//   busy                                                : RUN or DONE
//   acc_in1/acc_in2/acc_counter/acc_t -> datapath, acc_out <- datapath
module acc_share_sched
  import acc_share_sched_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int T_MAX = N - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_operand0,
  input  logic [N-1:0] req_operand1,
  input  logic [N-1:0] req_t0,
  input  logic [N-1:0] req_t1,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic [N-1:0] res_data,
  output logic         res_err,
  output logic         busy,
  output logic [N-1:0] acc_in1,
  output logic [N-1:0] acc_in2,
  output logic [N-1:0] acc_counter,
  output logic [N-1:0] acc_t,
  input  logic [N-1:0] acc_out
);

  localparam logic [N-1:0] T_MAX_V = N'(T_MAX);

  state_t       state, state_nxt;
  logic [N-1:0] acc_reg, operand, t_reg, counter;
  logic [N-1:0] op_sel, t_sel;
  logic [1:0]   grant;
  logic         accept, sel_id, t_legal, last_iter;

  acc_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == IDLE),
    .valid (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel_id    = grant[1];
  assign op_sel    = sel_id ? req_operand1 : req_operand0;
  assign t_sel     = sel_id ? req_t1 : req_t0;
  assign t_legal   = (t_sel != '0) && (t_sel <= T_MAX_V);
  assign last_iter = (counter == N'(iter_limit(32'(t_reg))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = t_legal ? RUN : DONE;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg  <= '0;
      operand  <= '0;
      t_reg    <= '0;
      counter  <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
      res_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          operand <= op_sel;
          t_reg   <= t_sel;
          res_id  <= sel_id;
          acc_reg <= '0;
          counter <= '0;
          // Illegal exponent: report straight away, datapath never runs.
          if (!t_legal) begin
            res_err  <= 1'b1;
            res_data <= '0;
          end
        end
        RUN: begin
          acc_reg <= acc_out;
          counter <= counter + N'(1);
          if (last_iter) begin
            res_data <= acc_out;
            res_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_valid   = (state == DONE);
  assign busy        = (state == RUN) || (state == DONE);
  assign acc_in1     = acc_reg;
  assign acc_in2     = operand;
  assign acc_t       = t_reg;
  assign acc_counter = (state == RUN) ? counter : '0;

endmodule

// File: tb/tb_acc_share_sched.sv
// Bench for acc_share_sched. The accumulator datapath model used here is
// acc_out = 2*acc_in1 + acc_in2^2 (mod 256), so operand 3 with t=2 gives
// 9, 27, 63, 135.
module tb_acc_share_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_ready;
  logic [7:0] req_operand0, req_operand1, req_t0, req_t1;
  logic       res_valid, res_ready, res_id, res_err, busy;
  logic [7:0] res_data, acc_in1, acc_in2, acc_counter, acc_t, acc_out;

  acc_share_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operand0(req_operand0), .req_operand1(req_operand1),
    .req_t0(req_t0), .req_t1(req_t1),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .res_err(res_err), .busy(busy),
    .acc_in1(acc_in1), .acc_in2(acc_in2), .acc_counter(acc_counter),
    .acc_t(acc_t), .acc_out(acc_out)
  );

  assign acc_out = (acc_in1 << 1) + acc_in2 * acc_in2;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_last = 1;  // reference arbiter history: last granted requester

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit t_ok(input logic [7:0] t);
    return (t >= 1) && (t <= 7);
  endfunction

  // Final sum of a job: 2^t applications of the datapath starting from 0.
  function automatic logic [7:0] ref_sum(input logic [7:0] op, input logic [7:0] t);
    int a = 0;
    if (!t_ok(t)) return 8'd0;
    for (int i = 0; i < (1 << t); i++) a = (2 * a + int'(op) * int'(op)) % 256;
    return 8'(a);
  endfunction

  function automatic logic ref_winner(input logic [1:0] v);
    if (v == 2'b11) return (model_last == 1) ? 1'b0 : 1'b1;
    return v[1];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    res_ready = 1'b0;
    model_last = 1;
    tick();
    rst_n = 1'b1;
  endtask

  // Present a request, expect the given winner, follow the job to its
  // result, hold the result for 'hold' cycles, then consume it.
  task automatic run_job(input logic [1:0] v, input logic [7:0] o0, input logic [7:0] o1,
                         input logic [7:0] t0, input logic [7:0] t1, input logic exp_id,
                         input logic [7:0] exp_data, input logic exp_err, input int hold,
                         input string nm);
    logic [7:0] tw;
    int k, lat;
    tw = exp_id ? t1 : t0;
    lat = exp_err ? 0 : (1 << tw);
    req_valid = v; req_operand0 = o0; req_operand1 = o1; req_t0 = t0; req_t1 = t1;
    #1;
    check({nm, "_ready"}, 32'(req_ready), exp_id ? 32'd2 : 32'd1);
    tick();
    model_last = int'(exp_id);
    req_valid = 2'b00;
    if (!exp_err) check({nm, "_acc_t"}, 32'(acc_t), 32'(tw));
    k = 0;
    while (!res_valid && k < 300) begin
      check($sformatf("%s_cnt%0d", nm, k), 32'(acc_counter), 32'(k));
      tick();
      k++;
    end
    check({nm, "_latency"}, 32'(k), 32'(lat));
    check({nm, "_id"}, 32'(res_id), 32'(exp_id));
    check({nm, "_data"}, 32'(res_data), 32'(exp_data));
    check({nm, "_err"}, 32'(res_err), 32'(exp_err));
    check({nm, "_cnt_done"}, 32'(acc_counter), 32'd0);
    for (int h = 0; h < hold; h++) begin
      req_valid = v;  // pending request must not be granted while in DONE
      tick();
      check({nm, "_hold_valid"}, 32'(res_valid), 32'd1);
      check({nm, "_hold_data"}, 32'({res_id, res_err, res_data}), 32'({exp_id, exp_err, exp_data}));
      check({nm, "_hold_busy"}, 32'(busy), 32'd1);
      check({nm, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 2'b00;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({nm, "_release"}, 32'({res_valid, busy}), 32'd0);
  endtask

  typedef struct {
    logic [1:0] v;
    logic [7:0] o0, o1, t0, t1;
    logic       id;
    logic [7:0] data;
    logic       err;
    int         hold;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // {valid, op0, op1, t0, t1, id, data, err, hold}; history starts at
    // last_grant=0 because the preceding single job belongs to requester 0.
    tbl[0] = '{2'b11, 8'd1,   8'd2,   8'd1, 8'd1,   1'b1, 8'd12,  1'b0, 0};
    tbl[1] = '{2'b11, 8'd1,   8'd2,   8'd1, 8'd1,   1'b0, 8'd3,   1'b0, 1};
    tbl[2] = '{2'b01, 8'd5,   8'd0,   8'd3, 8'd0,   1'b0, 8'd231, 1'b0, 5};
    tbl[3] = '{2'b10, 8'd0,   8'd255, 8'd0, 8'd1,   1'b1, 8'd3,   1'b0, 0};
    tbl[4] = '{2'b10, 8'd0,   8'd9,   8'd0, 8'd0,   1'b1, 8'd0,   1'b1, 2};
    tbl[5] = '{2'b01, 8'd9,   8'd0,   8'd8, 8'd0,   1'b0, 8'd0,   1'b1, 0};
    tbl[6] = '{2'b01, 8'd1,   8'd0,   8'd7, 8'd0,   1'b0, 8'd255, 1'b0, 0};
    tbl[7] = '{2'b10, 8'd0,   8'd16,  8'd0, 8'd1,   1'b1, 8'd0,   1'b0, 0};
    tbl[8] = '{2'b11, 8'd0,   8'd9,   8'd7, 8'd200, 1'b0, 8'd0,   1'b0, 1};

    rst_n = 1'b0;
    req_valid = 2'b00; res_ready = 1'b0;
    req_operand0 = '0; req_operand1 = '0; req_t0 = '0; req_t1 = '0;
    #2;
    check("rst_res", 32'({res_valid, res_id, res_err, res_data}), 32'd0);
    check("rst_busy_ready", 32'({busy, req_ready}), 32'd0);
    check("rst_acc", 32'({acc_in1, acc_in2, acc_counter, acc_t}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single job with 5 cycles of result backpressure.
    run_job(2'b01, 8'd3, 8'd0, 8'd2, 8'd0, 1'b0, 8'd135, 1'b0, 5, "single");

    for (int i = 0; i < 9; i++)
      run_job(tbl[i].v, tbl[i].o0, tbl[i].o1, tbl[i].t0, tbl[i].t1, tbl[i].id,
              tbl[i].data, tbl[i].err, tbl[i].hold, $sformatf("vec%0d", i));

    // Contention: both requesters held valid, results consumed at once.
    do_reset();
    req_operand0 = 8'd1; req_operand1 = 8'd2; req_t0 = 8'd1; req_t1 = 8'd1;
    req_valid = 2'b11; res_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      int k = 0;
      while (!res_valid && k < 20) begin tick(); k++; end
      check($sformatf("cont%0d_id", r), 32'(res_id), 32'(r % 2));
      check($sformatf("cont%0d_data", r), 32'(res_data), (r % 2) ? 32'd12 : 32'd3);
      tick();
    end
    req_valid = 2'b00; res_ready = 1'b0;

    // Mid-run reset aborts the job.
    do_reset();
    req_valid = 2'b01; req_operand0 = 8'd7; req_t0 = 8'd3;
    tick();
    req_valid = 2'b00;
    tick(); tick();
    check("midrst_cnt", 32'(acc_counter), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_clear", 32'({res_valid, busy, acc_counter, acc_in1}), 32'd0);
    tick();
    rst_n = 1'b1;
    model_last = 1;
    begin
      int seen = 0;
      for (int c = 0; c < 20; c++) begin tick(); if (res_valid) seen++; end
      check("midrst_no_result", 32'(seen), 32'd0);
    end
    run_job(2'b01, 8'd3, 8'd0, 8'd2, 8'd0, 1'b0, 8'd135, 1'b0, 0, "after_rst");

    // Randomized jobs against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [1:0] v;
      logic [7:0] o0, o1, t0, t1, tw;
      logic w;
      v  = 2'($urandom_range(1, 3));
      o0 = 8'($urandom); o1 = 8'($urandom);
      t0 = 8'($urandom_range(0, 9)); t1 = 8'($urandom_range(0, 9));
      w  = ref_winner(v);
      tw = w ? t1 : t0;
      run_job(v, o0, o1, t0, t1, w, ref_sum(w ? o1 : o0, tw), !t_ok(tw),
              int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_share_sched.md
Name: acc_share_sched

Overview:
- Scheduler that shares one combinational iterative accumulator datapath between two requesters.
- Arbitrates round-robin and latches the winner's operand and iteration exponent t.
- Sequences the datapath counter over 2^t cycles, feeding the registered sum back as the first addend.
- Returns the final sum with a valid/ready result handshake tagged by requester id.

Parameters:
- N, 8, datapath width: operands, sums, counter, t.
- T_MAX, N-1, largest legal t, so that 1<<t fits in N bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit0 = requester 0.
- req_ready  out  2  one-hot acceptance strobe; a request is accepted when valid&ready.
- req_operand0  in  N  addend for requester 0.
- req_operand1  in  N  addend for requester 1.
- req_t0  in  N  iteration exponent for requester 0.
- req_t1  in  N  iteration exponent for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_id  out  1  requester that owns res_data.
- res_data  out  N  final accumulated value.
- res_err  out  1  request rejected because t was illegal.
- busy  out  1  high in RUN and DONE.
- acc_in1  out  N  to datapath: current accumulator register.
- acc_in2  out  N  to datapath: latched operand.
- acc_counter  out  N  to datapath: iteration index.
- acc_t  out  N  to datapath: latched t.
- acc_out  in  N  from datapath: next accumulator value.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; acc_reg, operand, t, counter, res_data, res_err, res_id = 0.
  - req_ready=0, res_valid=0, busy=0.
  - last_grant=1, so requester 0 wins the first tie.
- Reset asserted mid-operation aborts the job; no result is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready is combinational: if exactly one req_valid is high, that bit; if both are high, the bit != last_grant; if neither, 0.
  - On an accepting edge: latch operand, t, id; set acc_reg=0, counter=0; set last_grant=id.
  - If 1<=t<=T_MAX, go to RUN.
  - If t is illegal: res_err=1, res_data=0, go directly to DONE; the datapath is not exercised.
- RUN:
  - acc_in1=acc_reg, acc_in2=operand, acc_counter=counter, acc_t=t.
  - Each edge: acc_reg<=acc_out and counter<=counter+1.
  - At the edge where counter==(1<<t)-1: res_data<=acc_out, res_err<=0, go to DONE.
  - Exactly 2^t RUN cycles. res_valid rises 2^t edges after the accepting edge.
  - req_ready=0; new requests wait, and requesters must hold valid and payload stable until accepted.
- DONE:
  - res_valid=1; res_id, res_data, res_err held stable.
  - On an edge with res_ready=1: go to IDLE and drop res_valid.
  - The earliest next acceptance is on the following edge; there is no same-cycle re-grant.
- Outside RUN: acc_counter=0; acc_in1, acc_in2, acc_t show the latched registers.
- Arithmetic: all sums wrap modulo 2^N as produced by the datapath; no overflow flag.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - N and T_MAX defaults;
  - an iteration-limit function returning (1<<t)-1.
- One sub-module, acc_rr_arb2: a 2-way round-robin arbiter with the last_grant register, an enable input (IDLE), and a one-hot grant output.
- The FSM, counter and result registers stay in acc_share_sched.
- The accumulator datapath is instantiated outside and connected through the acc_* ports.

Test Plan:
- Reset behaviour: rst_n low, then release. All outputs are 0 and busy=0; a request from requester 0 with t=2 is accepted on the first edge (req_ready=01).
- Single job: req0 operand=3, t=2 with the team's accumulator datapath model. acc_counter steps 0,1,2,3; res_valid is high 4 edges after acceptance; res_data=135, res_id=0, res_err=0.
- Contention: both requesters valid from reset, operand0=1, operand1=2, t=1, res_ready tied high. Grant order is 0,1,0,1 and res_id alternates.
- Illegal t: req1 with t=0, and separately with t=8 (N=8). Accepted, then res_valid on the next edge with res_err=1, res_data=0; acc_counter stays 0.
- Result backpressure: res_ready=0 for 5 cycles in DONE. res_data and res_id are stable, busy=1, req_ready=00. Raising res_ready returns the block to IDLE one edge later.
- Mid-run reset: assert rst_n low at counter=2 of a t=3 job. Outputs clear immediately; after release there is no res_valid until a new request completes.
